// File: rtl/kgp_pkg.sv
// Shared encodings and control-bundle types for the KGP-RISC pipeline control unit.
package kgp_pkg;

    localparam int unsigned RegAw = 5;
    localparam int unsigned AluFw = 4;

    // Major opcodes (instr[31:26])
    localparam logic [5:0] OP_ITYPE_HI = 6'b011001;
    localparam logic [5:0] OP_MOVE     = 6'b011010;
    localparam logic [5:0] OP_LD       = 6'b100001;
    localparam logic [5:0] OP_ST       = 6'b100010;
    localparam logic [5:0] OP_BR       = 6'b110100;
    localparam logic [3:0] OP_BCC_PFX  = 4'b1100;   // BLT/BGT/BEQ/BNE share this prefix

    // R-type funct range (instr[5:0])
    localparam logic [5:0] FUNCT_LO = 6'd1;
    localparam logic [5:0] FUNCT_HI = 6'd10;

    // ALU function codes
    localparam logic [AluFw-1:0] ALU_ADD = 4'd0;
    localparam logic [AluFw-1:0] ALU_SRL = 4'd9;

    typedef struct packed {
        logic             alusrc;
        logic [AluFw-1:0] alufunc;
        logic             mem_read;
        logic             mem_write;
        logic             regwrite;
        logic             memtoreg;
        logic             branch;
        logic             jump;
        logic             illegal;
        logic [RegAw-1:0] dest;
    } ctrl_t;

    typedef struct packed {
        logic             mem_read;
        logic             mem_write;
        logic             regwrite;
        logic             memtoreg;
        logic [RegAw-1:0] dest;
    } mem_ctrl_t;

    typedef struct packed {
        logic             regwrite;
        logic             memtoreg;
        logic [RegAw-1:0] dest;
    } wb_ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/kgp_decode.sv
// Combinational ID-stage decoder: instruction word to control bundle.
module kgp_decode
    import kgp_pkg::*;
(
    input  logic [31:0] instr_i,
    input  logic        valid_i,
    output ctrl_t       ctrl_o,
    output logic        uses_rt_o
);

    logic [5:0] op;
    logic [5:0] funct;

    assign op    = instr_i[31:26];
    assign funct = instr_i[5:0];

    always_comb begin
        ctrl_o    = CTRL_BUBBLE;
        uses_rt_o = 1'b0;
        if (valid_i && (instr_i != '0)) begin
            unique case (op[5:4])
                2'b00: begin
                    if (funct >= FUNCT_LO && funct <= FUNCT_HI) begin
                        ctrl_o.alufunc  = 4'(funct - FUNCT_LO);
                        ctrl_o.regwrite = 1'b1;
                        ctrl_o.dest     = instr_i[15:11];
                        uses_rt_o       = 1'b1;
                    end else begin
                        ctrl_o.illegal = 1'b1;
                    end
                end
                2'b01: begin
                    // 010000..011001 map directly onto the low opcode nibble
                    if (op <= OP_ITYPE_HI || op == OP_MOVE) begin
                        ctrl_o.alufunc  = (op == OP_MOVE) ? ALU_ADD : op[3:0];
                        ctrl_o.alusrc   = 1'b1;
                        ctrl_o.regwrite = 1'b1;
                        ctrl_o.dest     = instr_i[20:16];
                    end else begin
                        ctrl_o.illegal = 1'b1;
                    end
                end
                2'b10: begin
                    if (op == OP_LD) begin
                        ctrl_o.alusrc   = 1'b1;
                        ctrl_o.alufunc  = ALU_ADD;
                        ctrl_o.mem_read = 1'b1;
                        ctrl_o.regwrite = 1'b1;
                        ctrl_o.memtoreg = 1'b1;
                        ctrl_o.dest     = instr_i[20:16];
                    end else if (op == OP_ST) begin
                        ctrl_o.alusrc    = 1'b1;
                        ctrl_o.alufunc   = ALU_ADD;
                        ctrl_o.mem_write = 1'b1;
                        uses_rt_o        = 1'b1;
                    end else begin
                        ctrl_o.illegal = 1'b1;
                    end
                end
                2'b11: begin
                    if (op[5:2] == OP_BCC_PFX) begin
                        ctrl_o.branch = 1'b1;
                        uses_rt_o     = 1'b1;
                    end else if (op == OP_BR) begin
                        ctrl_o.jump = 1'b1;
                    end else begin
                        ctrl_o.illegal = 1'b1;
                    end
                end
                default: ctrl_o = CTRL_BUBBLE;
            endcase
        end
    end

endmodule

// File: rtl/kgp_pipe_ctrl.sv
// KGP-RISC pipeline control: ID decode, ID/EX..MEM/WB control stages, hazards, perf counters.
module kgp_pipe_ctrl
    import kgp_pkg::*;
#(
    parameter int unsigned REG_W  = 5,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned ALUF_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       id_instr,
    input  logic              id_valid,
    input  logic              ex_branch_cond,
    input  logic              mem_ready,
    output logic              ex_alusrc,
    output logic [ALUF_W-1:0] ex_alufunc,
    output logic              mem_read,
    output logic              mem_write,
    output logic              wb_regwrite,
    output logic              wb_memtoreg,
    output logic [REG_W-1:0]  wb_dest,
    output logic              pcsrc,
    output logic              pc_stall,
    output logic              ifid_stall,
    output logic              if_flush,
    output logic              illegal_op,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    ctrl_t            id_ctrl;
    logic             id_uses_rt;
    logic [RegAw-1:0] id_rs;
    logic [RegAw-1:0] id_rt;

    ctrl_t            idex_d, idex_q;
    mem_ctrl_t        exmem_d, exmem_q;
    wb_ctrl_t         memwb_d, memwb_q;
    logic             illegal_d, illegal_q;
    logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;

    logic freeze;
    logic redirect;
    logic load_use;
    logic stall;

    kgp_decode u_decode (
        .instr_i   (id_instr),
        .valid_i   (id_valid),
        .ctrl_o    (id_ctrl),
        .uses_rt_o (id_uses_rt)
    );

    assign id_rs = id_instr[25:21];
    assign id_rt = id_instr[20:16];

    assign freeze   = (exmem_q.mem_read | exmem_q.mem_write) & ~mem_ready;
    assign redirect = ~freeze & (idex_q.jump | (idex_q.branch & ex_branch_cond));
    assign load_use = idex_q.mem_read && (idex_q.dest != '0) &&
                      ((idex_q.dest == id_rs) || ((idex_q.dest == id_rt) && id_uses_rt));
    // A redirect squashes the dependent instruction, so it wins over the load-use stall
    assign stall    = freeze | (load_use & ~redirect);

    always_comb begin
        idex_d    = idex_q;
        exmem_d   = exmem_q;
        memwb_d   = memwb_q;
        illegal_d = 1'b0;
        if (!freeze) begin
            idex_d            = (redirect || load_use) ? CTRL_BUBBLE : id_ctrl;
            exmem_d.mem_read  = idex_q.mem_read;
            exmem_d.mem_write = idex_q.mem_write;
            exmem_d.regwrite  = idex_q.regwrite;
            exmem_d.memtoreg  = idex_q.memtoreg;
            exmem_d.dest      = idex_q.dest;
            memwb_d.regwrite  = exmem_q.regwrite;
            memwb_d.memtoreg  = exmem_q.memtoreg;
            memwb_d.dest      = exmem_q.dest;
            illegal_d         = idex_q.illegal;
        end
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        flush_cnt_d = flush_cnt_q;
        if (redirect && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idex_q      <= CTRL_BUBBLE;
            exmem_q     <= '0;
            memwb_q     <= '0;
            illegal_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            idex_q      <= idex_d;
            exmem_q     <= exmem_d;
            memwb_q     <= memwb_d;
            illegal_q   <= illegal_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ex_alusrc   = idex_q.alusrc;
    assign ex_alufunc  = ALUF_W'(idex_q.alufunc);
    assign mem_read    = exmem_q.mem_read;
    assign mem_write   = exmem_q.mem_write;
    assign wb_regwrite = memwb_q.regwrite;
    assign wb_memtoreg = memwb_q.memtoreg;
    assign wb_dest     = REG_W'(memwb_q.dest);
    assign pcsrc       = redirect;
    assign if_flush    = redirect;
    assign pc_stall    = stall;
    assign ifid_stall  = stall;
    assign illegal_op  = illegal_q;
    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_kgp_pipe_ctrl.sv
// Table-driven bench for kgp_pipe_ctrl: one row per cycle, plus a counter-saturation sequence.
module tb_kgp_pipe_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] id_instr;
    logic        id_valid;
    logic        ex_branch_cond;
    logic        mem_ready;
    logic        ex_alusrc;
    logic [3:0]  ex_alufunc;
    logic        mem_read;
    logic        mem_write;
    logic        wb_regwrite;
    logic        wb_memtoreg;
    logic [4:0]  wb_dest;
    logic        pcsrc;
    logic        pc_stall;
    logic        ifid_stall;
    logic        if_flush;
    logic        illegal_op;
    logic [15:0] stall_count;
    logic [15:0] flush_count;

    kgp_pipe_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .id_instr       (id_instr),
        .id_valid       (id_valid),
        .ex_branch_cond (ex_branch_cond),
        .mem_ready      (mem_ready),
        .ex_alusrc      (ex_alusrc),
        .ex_alufunc     (ex_alufunc),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .wb_regwrite    (wb_regwrite),
        .wb_memtoreg    (wb_memtoreg),
        .wb_dest        (wb_dest),
        .pcsrc          (pcsrc),
        .pc_stall       (pc_stall),
        .ifid_stall     (ifid_stall),
        .if_flush       (if_flush),
        .illegal_op     (illegal_op),
        .stall_count    (stall_count),
        .flush_count    (flush_count)
    );

    always #5 clk = ~clk;

    // ex={alusrc,alufunc} mem={mem_read,mem_write} wb={regwrite,memtoreg,dest} ctl={pcsrc,stall,illegal}
    typedef struct {
        logic        rst;
        logic [31:0] instr;
        logic        valid;
        logic        cond;
        logic        ready;
        logic [4:0]  ex;
        logic [1:0]  mem;
        logic [6:0]  wb;
        logic [2:0]  ctl;
        logic [15:0] sc;
        logic [15:0] fc;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] funct);
        return {6'b000000, rs, rt, rd, 5'b00000, funct};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt);
        return {op, rs, rt, 16'h0004};
    endfunction

    task automatic add(input logic rst, input logic [31:0] instr, input logic valid,
                       input logic cond, input logic ready, input logic [4:0] ex,
                       input logic [1:0] mem, input logic [6:0] wb, input logic [2:0] ctl,
                       input logic [15:0] sc, input logic [15:0] fc);
        vec_t v;
        v.rst = rst; v.instr = instr; v.valid = valid; v.cond = cond; v.ready = ready;
        v.ex = ex; v.mem = mem; v.wb = wb; v.ctl = ctl; v.sc = sc; v.fc = fc;
        vecs.push_back(v);
    endtask

    task automatic op(input logic [31:0] instr, input logic [4:0] ex, input logic [1:0] mem,
                      input logic [6:0] wb, input logic [2:0] ctl, input logic [15:0] sc,
                      input logic [15:0] fc);
        add(1'b0, instr, 1'b1, 1'b0, 1'b1, ex, mem, wb, ctl, sc, fc);
    endtask

    task automatic nop(input logic [4:0] ex, input logic [1:0] mem, input logic [6:0] wb,
                       input logic [2:0] ctl, input logic [15:0] sc, input logic [15:0] fc);
        add(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, ex, mem, wb, ctl, sc, fc);
    endtask

    function automatic logic [50:0] observe();
        return {ex_alusrc, ex_alufunc, mem_read, mem_write, wb_regwrite, wb_memtoreg, wb_dest,
                pcsrc, if_flush, pc_stall, ifid_stall, illegal_op, stall_count, flush_count};
    endfunction

    task automatic check(input string name, input logic [50:0] got, input logic [50:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    logic [31:0] i_a, i_b, i_c, i_d, i_ld4, i_add2, i_ld6, i_addi6, i_ld7, i_st7;
    logic [31:0] i_beq, i_bne, i_br, i_ill, i_badf;

    initial begin
        i_a     = rtype(5'd1, 5'd2, 5'd3, 6'd1);        // ADD r3,r1,r2
        i_b     = rtype(5'd5, 5'd6, 5'd7, 6'd10);       // SRL r7 -> alufunc 9
        i_c     = itype(6'b010011, 5'd1, 5'd8);         // I-type alufunc 3 -> r8
        i_d     = itype(6'b011010, 5'd2, 5'd9);         // MOVE -> r9
        i_ld4   = itype(6'b100001, 5'd1, 5'd4);
        i_add2  = rtype(5'd4, 5'd1, 5'd5, 6'd1);        // ADD r5,r4,r1
        i_ld6   = itype(6'b100001, 5'd1, 5'd6);
        i_addi6 = itype(6'b010000, 5'd2, 5'd6);         // rt=6 but rt is not a source
        i_ld7   = itype(6'b100001, 5'd0, 5'd7);
        i_st7   = itype(6'b100010, 5'd0, 5'd7);         // store data from r7
        i_beq   = itype(6'b110010, 5'd1, 5'd2);
        i_bne   = itype(6'b110011, 5'd1, 5'd2);
        i_br    = itype(6'b110100, 5'd2, 5'd0);
        i_ill   = 32'hFC00_0000;
        i_badf  = rtype(5'd1, 5'd2, 5'd3, 6'd11);

        // Plain ALU stream
        add(1'b1, 32'h0, 1'b0, 1'b0, 1'b1, 5'h0, 2'b00, 7'h0, 3'b000, 16'd0, 16'd0);
        op(i_a, 5'h0, 2'b00, 7'h0, 3'b000, 16'd0, 16'd0);
        op(i_b, 5'h0, 2'b00, 7'h0, 3'b000, 16'd0, 16'd0);
        op(i_c, {1'b0, 4'd9}, 2'b00, 7'h0, 3'b000, 16'd0, 16'd0);
        op(i_d, {1'b1, 4'd3}, 2'b00, {2'b10, 5'd3}, 3'b000, 16'd0, 16'd0);
        nop({1'b1, 4'd0}, 2'b00, {2'b10, 5'd7}, 3'b000, 16'd0, 16'd0);
        nop(5'h0, 2'b00, {2'b10, 5'd8}, 3'b000, 16'd0, 16'd0);
        nop(5'h0, 2'b00, {2'b10, 5'd9}, 3'b000, 16'd0, 16'd0);
        nop(5'h0, 2'b00, 7'h0, 3'b000, 16'd0, 16'd0);
        // Load-use on rs: one stall, ADD held in ID
        op(i_ld4, 5'h0, 2'b00, 7'h0, 3'b000, 16'd0, 16'd0);
        op(i_add2, {1'b1, 4'd0}, 2'b00, 7'h0, 3'b010, 16'd0, 16'd0);
        op(i_add2, 5'h0, 2'b10, 7'h0, 3'b000, 16'd1, 16'd0);
        nop(5'h0, 2'b00, {2'b11, 5'd4}, 3'b000, 16'd1, 16'd0);
        nop(5'h0, 2'b00, 7'h0, 3'b000, 16'd1, 16'd0);
        nop(5'h0, 2'b00, {2'b10, 5'd5}, 3'b000, 16'd1, 16'd0);
        // Load followed by I-type with matching rt: no hazard
        op(i_ld6, 5'h0, 2'b00, 7'h0, 3'b000, 16'd1, 16'd0);
        op(i_addi6, {1'b1, 4'd0}, 2'b00, 7'h0, 3'b000, 16'd1, 16'd0);
        nop({1'b1, 4'd0}, 2'b10, 7'h0, 3'b000, 16'd1, 16'd0);
        nop(5'h0, 2'b00, {2'b11, 5'd6}, 3'b000, 16'd1, 16'd0);
        nop(5'h0, 2'b00, {2'b10, 5'd6}, 3'b000, 16'd1, 16'd0);
        // Load-use through store rt
        op(i_ld7, 5'h0, 2'b00, 7'h0, 3'b000, 16'd1, 16'd0);
        op(i_st7, {1'b1, 4'd0}, 2'b00, 7'h0, 3'b010, 16'd1, 16'd0);
        op(i_st7, 5'h0, 2'b10, 7'h0, 3'b000, 16'd2, 16'd0);
        nop({1'b1, 4'd0}, 2'b00, {2'b11, 5'd7}, 3'b000, 16'd2, 16'd0);
        nop(5'h0, 2'b01, 7'h0, 3'b000, 16'd2, 16'd0);
        nop(5'h0, 2'b00, 7'h0, 3'b000, 16'd2, 16'd0);
        // Taken BEQ squashes the ADD behind it
        op(i_beq, 5'h0, 2'b00, 7'h0, 3'b000, 16'd2, 16'd0);
        add(1'b0, i_a, 1'b1, 1'b1, 1'b1, 5'h0, 2'b00, 7'h0, 3'b100, 16'd2, 16'd0);
        add(1'b0, i_b, 1'b1, 1'b1, 1'b1, 5'h0, 2'b00, 7'h0, 3'b000, 16'd2, 16'd1);
        nop({1'b0, 4'd9}, 2'b00, 7'h0, 3'b000, 16'd2, 16'd1);
        nop(5'h0, 2'b00, 7'h0, 3'b000, 16'd2, 16'd1);
        nop(5'h0, 2'b00, {2'b10, 5'd7}, 3'b000, 16'd2, 16'd1);
        // Not-taken BNE; cond alone never redirects
        op(i_bne, 5'h0, 2'b00, 7'h0, 3'b000, 16'd2, 16'd1);
        add(1'b0, i_a, 1'b1, 1'b0, 1'b1, 5'h0, 2'b00, 7'h0, 3'b000, 16'd2, 16'd1);
        add(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 5'h0, 2'b00, 7'h0, 3'b000, 16'd2, 16'd1);
        nop(5'h0, 2'b00, 7'h0, 3'b000, 16'd2, 16'd1);
        nop(5'h0, 2'b00, {2'b10, 5'd3}, 3'b000, 16'd2, 16'd1);
        // Freeze with BR waiting in EX, redirect on first ready cycle
        op(i_ld4, 5'h0, 2'b00, 7'h0, 3'b000, 16'd2, 16'd1);
        op(i_br, {1'b1, 4'd0}, 2'b00, 7'h0, 3'b000, 16'd2, 16'd1);
        add(1'b0, i_a, 1'b1, 1'b0, 1'b0, 5'h0, 2'b10, 7'h0, 3'b010, 16'd2, 16'd1);
        add(1'b0, i_a, 1'b1, 1'b0, 1'b0, 5'h0, 2'b10, 7'h0, 3'b010, 16'd3, 16'd1);
        add(1'b0, i_a, 1'b1, 1'b0, 1'b0, 5'h0, 2'b10, 7'h0, 3'b010, 16'd4, 16'd1);
        add(1'b0, i_a, 1'b1, 1'b0, 1'b1, 5'h0, 2'b10, 7'h0, 3'b100, 16'd5, 16'd1);
        nop(5'h0, 2'b00, {2'b11, 5'd4}, 3'b000, 16'd5, 16'd2);
        add(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'h0, 2'b00, 7'h0, 3'b000, 16'd5, 16'd2);
        nop(5'h0, 2'b00, 7'h0, 3'b000, 16'd5, 16'd2);
        // Illegal encodings pulse once after leaving EX; invalid slot never does
        op(i_ill, 5'h0, 2'b00, 7'h0, 3'b000, 16'd5, 16'd2);
        nop(5'h0, 2'b00, 7'h0, 3'b000, 16'd5, 16'd2);
        op(i_badf, 5'h0, 2'b00, 7'h0, 3'b001, 16'd5, 16'd2);
        nop(5'h0, 2'b00, 7'h0, 3'b000, 16'd5, 16'd2);
        nop(5'h0, 2'b00, 7'h0, 3'b001, 16'd5, 16'd2);
        add(1'b0, i_ill, 1'b0, 1'b0, 1'b1, 5'h0, 2'b00, 7'h0, 3'b000, 16'd5, 16'd2);
        nop(5'h0, 2'b00, 7'h0, 3'b000, 16'd5, 16'd2);
        nop(5'h0, 2'b00, 7'h0, 3'b000, 16'd5, 16'd2);
        // Reset during a freeze clears everything on that edge
        op(i_ld4, 5'h0, 2'b00, 7'h0, 3'b000, 16'd5, 16'd2);
        nop({1'b1, 4'd0}, 2'b00, 7'h0, 3'b000, 16'd5, 16'd2);
        add(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'h0, 2'b10, 7'h0, 3'b010, 16'd5, 16'd2);
        add(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 5'h0, 2'b10, 7'h0, 3'b010, 16'd6, 16'd2);
        add(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 5'h0, 2'b00, 7'h0, 3'b000, 16'd0, 16'd0);

        reset = 1'b1; id_instr = '0; id_valid = 1'b0; ex_branch_cond = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset          = vecs[i].rst;
            id_instr       = vecs[i].instr;
            id_valid       = vecs[i].valid;
            ex_branch_cond = vecs[i].cond;
            mem_ready      = vecs[i].ready;
            #1;
            check($sformatf("row%0d", i), observe(),
                  {vecs[i].ex, vecs[i].mem, vecs[i].wb, vecs[i].ctl[2], vecs[i].ctl[2],
                   vecs[i].ctl[1], vecs[i].ctl[1], vecs[i].ctl[0], vecs[i].sc, vecs[i].fc});
        end

        // Long freeze: stall counter must stick at all-ones rather than wrap
        @(negedge clk);
        id_instr = i_ld4; id_valid = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        id_instr = '0; id_valid = 1'b0;
        @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check("sat_start", 51'({pc_stall, stall_count}), 51'({1'b1, 16'd0}));
        repeat (65534) @(posedge clk);
        @(negedge clk);
        #1;
        check("sat_near", 51'({pc_stall, stall_count}), 51'({1'b1, 16'd65534}));
        repeat (7) @(posedge clk);
        @(negedge clk);
        #1;
        check("sat_hold", 51'({pc_stall, mem_read, stall_count}), 51'({2'b11, 16'hFFFF}));
        mem_ready = 1'b1;
        @(negedge clk);
        #1;
        check("sat_release", 51'({pc_stall, wb_memtoreg, wb_dest, stall_count}),
              51'({1'b0, 1'b1, 5'd4, 16'hFFFF}));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/kgp_pipe_ctrl.md
Name: kgp_pipe_ctrl

Overview:
Pipelined control unit for the 5-stage KGP-RISC core (IF/ID/EX/MEM/WB). It decodes the ID-stage instruction into a control bundle and carries that bundle through registered ID/EX, EX/MEM and MEM/WB control stages. It detects load-use hazards and issues stalls, resolves branch/jump redirects from EX and flushes the younger slots, and freezes the pipe on data-memory wait states. Saturating stall/flush performance counters are included.

Parameters:
REG_W, 5, register-address width (rs=instr[25:21], rt=instr[20:16], rd=instr[15:11] at default)
CNT_W, 16, width of each performance counter
ALUF_W, 4, ALU function code width

Ports:
clk  in  1  core clock, rising edge
reset  in  1  synchronous, active-high
id_instr  in  32  instruction in ID
id_valid  in  1  ID holds a real instruction
ex_branch_cond  in  1  branch comparison result from EX datapath
mem_ready  in  1  data memory completes the MEM access this cycle
ex_alusrc  out  1  EX: immediate operand select
ex_alufunc  out  ALUF_W  EX: ALU operation
mem_read  out  1  MEM: load
mem_write  out  1  MEM: store
wb_regwrite  out  1  WB: register write enable
wb_memtoreg  out  1  WB: select load data
wb_dest  out  REG_W  WB: destination register
pcsrc  out  1  redirect PC to branch/jump target
pc_stall  out  1  hold PC
ifid_stall  out  1  hold IF/ID register
if_flush  out  1  squash IF/ID contents
illegal_op  out  1  one-cycle pulse: undefined opcode reached EX
stall_count  out  CNT_W  cycles with pc_stall=1
flush_count  out  CNT_W  redirects taken

Behaviour:
- Reset (synchronous): all stage-control registers become bubbles (all enables 0, dest 0), counters 0, every output 0.
- Decode (combinational in ID): class=instr[31:30]. 00 is R-type; alufunc comes from funct instr[5:0]: 1..10 map to 0..9 (ADD..SRL); dest=rd. 01 is I-type; opcodes 010000..011001 map to alufunc 0..9; MOVE 011010 maps to 0; alusrc=1; dest=rt. LD 100001 sets alusrc, mem_read, regwrite, memtoreg, alufunc 0, dest=rt. ST 100010 sets alusrc, mem_write, alufunc 0. BLT/BGT/BEQ/BNE 110000..110011 set branch. BR 110100 sets jump.
- id_instr==0 or id_valid=0 produces a bubble. Any other undefined encoding produces a bubble with the illegal flag set.
- ID/EX to EX/MEM to MEM/WB advance one stage per cycle. Latency from ID to a WB control value is 3 cycles.
- pcsrc is combinational: ex_jump | (ex_branch & ex_branch_cond), gated by !freeze. if_flush=pcsrc.
- On pcsrc, the next ID/EX load is a bubble. flush_count increments.
- Load-use hazard (load_use): ex_mem_read & ex_dest!=0 & (ex_dest==id_rs | (ex_dest==id_rt & id uses rt)).
  - id uses rt for R-type, ST and branches.
  - Response: pc_stall=1, ifid_stall=1, ID/EX loads a bubble.
  - Exactly one stall cycle; the hazard clears because EX then holds a bubble.
- Freeze: (mem_read|mem_write) & !mem_ready.
  - All three stage registers hold.
  - pc_stall=1, ifid_stall=1, pcsrc/if_flush forced 0.
  - A pending EX redirect takes effect on the first unfrozen cycle.
- Priority: reset > freeze > redirect > load_use. A redirect coinciding with load_use flushes; no stall is issued.
- illegal_op pulses for one cycle when an illegal-flagged bundle leaves EX. It is suppressed during freeze.
- Counters saturate at all-ones. stall_count counts every pc_stall cycle, freeze or load_use.
- Reset asserted mid-freeze or mid-stall clears all state on that edge. There is no residual redirect.

Decomposition:
- Package kgp_pkg:
  - opcode and funct constants
  - ALU function codes
  - packed struct ctrl_t {alusrc, alufunc, mem_read, mem_write, regwrite, memtoreg, branch, jump, illegal, dest}
  - constant CTRL_BUBBLE
- Sub-module kgp_decode: purely combinational instr to ctrl_t.
- kgp_pipe_ctrl owns the stage registers, hazard logic and counters.

Test Plan:
1. ADD r3,r1,r2 (funct 000001) with mem_ready=1 -> ex_alufunc=0 one cycle after ID. wb_regwrite=1 and wb_dest=3 three cycles after ID. No stalls.
2. LD r4 followed immediately by ADD r5,r4,r1 -> one cycle with pc_stall=ifid_stall=1 and a bubble in EX. stall_count=1. ADD reaches WB one cycle late.
3. BEQ in EX with ex_branch_cond=1 -> pcsrc=if_flush=1 for one cycle. The next EX slot is a bubble. flush_count=1. With cond=0 -> no redirect.
4. LD in MEM with mem_ready=0 for 3 cycles while BR is in EX -> all stages hold. pcsrc=0 during the freeze. pcsrc=1 on the first cycle mem_ready=1. stall_count=3.
5. Opcode 111111 -> EX bubble with no enables. illegal_op pulses once.
6. Reset asserted during a freeze -> all outputs 0 and counters 0 on the next edge. A 2^CNT_W+5-cycle freeze leaves stall_count saturated at all-ones.
